// File: rtl/dpram_stream_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dpram_stream_fifo
//
// Valid/ready stream FIFO controller wrapped around one external dual-port RAM
// (dpram_wrapper). Port A is the write port and port B the read port. A small
// prefetch buffer (obuf, N_DELAY+1 entries) hides the RAM read latency so the
// FIFO sustains one word per cycle.
//
// Handshake: a word moves on a stream interface in every cycle where valid and
// ready are both high. m_valid never depends on m_ready. m_data is held stable
// while m_valid && !m_ready. s_ready does not depend on s_valid.
//
// Optional feature macro: DPRAM_FIFO_LEVEL_EN adds the registered 'level'
// output (words held in RAM + in flight + in obuf).
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   clear                      synchronous flush of all FIFO state
//   s_valid/s_ready/s_data     input stream
//   m_valid/m_ready/m_data     output stream
//   mem_ena/wea/addra/dia      RAM write port
//   mem_enb/addrb              RAM read port request
//   mem_dob                    RAM read data, N_DELAY cycles after mem_enb
//   level (optional)           fill level, registered
// -----------------------------------------------------------------------------
module dpram_stream_fifo #(
   parameter int DW      = 32,
   parameter int AW      = 8,
   parameter int DEPTH   = 208,
   parameter int N_DELAY = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clear,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          mem_ena,
   output logic          mem_wea,
   output logic [AW-1:0] mem_addra,
   output logic [DW-1:0] mem_dia,
   output logic          mem_enb,
   output logic [AW-1:0] mem_addrb,
   input  logic [DW-1:0] mem_dob
`ifdef DPRAM_FIFO_LEVEL_EN
   ,
   output logic [AW+1:0] level
`endif
);

   localparam int OB = N_DELAY + 1;          // obuf entries
   localparam int CW = $clog2(OB + 1);       // width of obuf/in-flight counts
   localparam int IW = $clog2(OB);           // obuf index width (OB >= 2)

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);
   localparam logic [IW-1:0] OLAST_C = IW'(OB - 1);
   localparam logic [CW:0]   OB_C    = (CW+1)'(OB);

   // state
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]        mem_cnt_q, mem_cnt_d;
   logic [N_DELAY-1:0] vld_q, vld_d;
   logic [DW-1:0]      obuf_q [OB];
   logic [IW-1:0]      obuf_wr_q, obuf_wr_d;
   logic [IW-1:0]      obuf_rd_q, obuf_rd_d;
   logic [CW-1:0]      obuf_cnt_q, obuf_cnt_d;

   // combinational
   logic          push;
   logic          pop;
   logic          issue;
   logic          cap;
   logic [CW-1:0] inflight;
   logic [CW:0]   need;

   // rstn gates s_ready so the write port stays idle while reset is asserted.
   assign s_ready = rstn && (mem_cnt_q != DEPTH_C) && !clear;
   assign push    = s_valid && s_ready;
   assign m_valid = (obuf_cnt_q != '0);
   assign pop     = m_valid && m_ready;
   assign m_data  = obuf_q[obuf_rd_q];

   // Returning RAM data is dropped in a clear cycle; the in-flight pipe is
   // zeroed at the same edge, so nothing older than the clear ever lands.
   assign cap = vld_q[N_DELAY-1] && !clear;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < N_DELAY; i++) begin
         inflight = inflight + CW'(vld_q[i]);
      end
   end

   // Slots obuf will need after this cycle, counting reads already in flight.
   // pop implies obuf_cnt_q >= 1, so the subtraction never underflows.
   assign need  = (CW+1)'(obuf_cnt_q) + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue = (mem_cnt_q != '0) && (need < OB_C) && !clear;

   assign mem_ena   = push;
   assign mem_wea   = push;
   assign mem_addra = wr_ptr_q;
   assign mem_dia   = push ? s_data : '0;
   assign mem_enb   = issue;
   assign mem_addrb = rd_ptr_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mem_cnt_d  = mem_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
      obuf_cnt_d = obuf_cnt_q + CW'(cap) - CW'(pop);
      obuf_wr_d  = obuf_wr_q;
      obuf_rd_d  = obuf_rd_q;
      vld_d      = '0;

      vld_d[0] = issue;
      for (int i = 1; i < N_DELAY; i++) begin
         vld_d[i] = vld_q[i-1];
      end

      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + AW'(1);
      end
      if (issue) begin
         rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + AW'(1);
      end
      if (cap) begin
         obuf_wr_d = (obuf_wr_q == OLAST_C) ? '0 : obuf_wr_q + IW'(1);
      end
      if (pop) begin
         obuf_rd_d = (obuf_rd_q == OLAST_C) ? '0 : obuf_rd_q + IW'(1);
      end

      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         mem_cnt_d  = '0;
         obuf_cnt_d = '0;
         obuf_wr_d  = '0;
         obuf_rd_d  = '0;
         vld_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_cnt_q  <= '0;
         vld_q      <= '0;
         obuf_wr_q  <= '0;
         obuf_rd_q  <= '0;
         obuf_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_cnt_q  <= mem_cnt_d;
         vld_q      <= vld_d;
         obuf_wr_q  <= obuf_wr_d;
         obuf_rd_q  <= obuf_rd_d;
         obuf_cnt_q <= obuf_cnt_d;
      end
   end

   // Data storage is only reset so that m_data reads 0 out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < OB; i++) begin
            obuf_q[i] <= '0;
         end
      end else if (cap) begin
         obuf_q[obuf_wr_q] <= mem_dob;
      end
   end

`ifdef DPRAM_FIFO_LEVEL_EN
   logic [CW-1:0] inflight_d;
   logic [AW+1:0] level_d;
   logic [AW+1:0] level_q;

   always_comb begin
      inflight_d = '0;
      for (int i = 0; i < N_DELAY; i++) begin
         inflight_d = inflight_d + CW'(vld_d[i]);
      end
      // next-state terms are already zero in a clear cycle
      level_d = (AW+2)'(mem_cnt_d) + (AW+2)'(inflight_d) + (AW+2)'(obuf_cnt_d);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;
`endif

endmodule

// File: tb/tb_dpram_stream_fifo.sv
`timescale 1ns/1ps
module tb_dpram_stream_fifo;

  localparam int DW = 32;
  localparam int AW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          mem_ena, mem_wea, mem_enb;
  logic [AW-1:0] mem_addra, mem_addrb;
  logic [DW-1:0] mem_dia;
  logic [DW-1:0] mem_dob = '0;
`ifdef DPRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  dpram_stream_fifo dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .mem_ena   (mem_ena),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dia   (mem_dia),
    .mem_enb   (mem_enb),
    .mem_addrb (mem_addrb),
    .mem_dob   (mem_dob)
`ifdef DPRAM_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  // dual-port RAM model, one cycle registered read
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_ena && mem_wea) ram[mem_addra] <= mem_dia;
    if (mem_enb) mem_dob <= ram[mem_addrb];
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // directed vectors, one per cycle, outputs sampled at the falling edge
  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          clr;
    logic          e_sr;
    logic          e_mv;
    logic [DW-1:0] e_md;
    logic          e_ena;
    logic [AW-1:0] e_addra;
    logic          e_enb;
    logic [AW-1:0] e_addrb;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int pushed, popped, cyc, first_push, first_out, bubbles, outs, stale;
    logic started, wrap_seen, prev_stall, done;
    logic [AW-1:0] prev_addra;
    logic [DW-1:0] prev_data, got;

    //                sv  sd            mr clr  sr mv md            ena addra enb addrb
    vecs[0]  = '{1'b1, 32'hA5A50001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 8'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 1'b1, 8'd0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A50001, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 32'h11,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 8'd1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 32'h22,       1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 8'd2, 1'b1, 8'd1};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 1'b1, 8'd2};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h11,       1'b0, 8'd0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h11,       1'b0, 8'd0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       1'b0, 8'd0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 32'h33,       1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0, 8'd0};

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_mem_ena", mem_ena, 0);
    chk("rst_mem_enb", mem_enb, 0);
`ifdef DPRAM_FIFO_LEVEL_EN
    chk("rst_level", level, 0);
`endif
    next_cycle();

    // ---------------- vector table ----------------
    for (int i = 0; i < 14; i++) begin
      s_valid = vecs[i].sv;
      s_data  = vecs[i].sd;
      m_ready = vecs[i].mr;
      clear   = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_sr);
      chk($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].e_mv);
      if (vecs[i].e_mv) chk($sformatf("vec%0d_m_data", i), m_data, vecs[i].e_md);
      chk($sformatf("vec%0d_mem_ena", i), mem_ena, vecs[i].e_ena);
      chk($sformatf("vec%0d_mem_enb", i), mem_enb, vecs[i].e_enb);
      if (vecs[i].e_ena) begin
        chk($sformatf("vec%0d_mem_wea", i), mem_wea, 1);
        chk($sformatf("vec%0d_mem_addra", i), mem_addra, vecs[i].e_addra);
        chk($sformatf("vec%0d_mem_dia", i), mem_dia, vecs[i].sd);
      end
      if (vecs[i].e_enb) chk($sformatf("vec%0d_mem_addrb", i), mem_addrb, vecs[i].e_addrb);
      next_cycle();
    end
    s_valid = 1'b0;
    clear = 1'b0;

    // ---------------- fill to capacity ----------------
    m_ready = 1'b0;
    s_valid = 1'b1;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      s_data = n;
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back(n);
        n++;
      end else begin
        done = 1'b1;
      end
      next_cycle();
    end
    s_valid = 1'b0;
    chk("fill_count", n, 210);
    @(negedge clk);
    chk("fill_s_ready_low", s_ready, 0);
`ifdef DPRAM_FIFO_LEVEL_EN
    chk("fill_level", level, 210);
`endif
    next_cycle();
    m_ready = 1'b1;
    for (int i = 0; i < 210; i++) begin
      @(negedge clk);
      chk("drain_m_valid", m_valid, 1);
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
      chk($sformatf("drain_data_%0d", i), m_data, got);
      next_cycle();
    end
    @(negedge clk);
    chk("drain_done_m_valid", m_valid, 0);
    next_cycle();

    // ---------------- full-rate streaming ----------------
    exp_q.delete();
    pushed = 0; popped = 0; cyc = 0; bubbles = 0;
    first_push = -1; first_out = -1;
    started = 1'b0; wrap_seen = 1'b0; prev_addra = '0;
    m_ready = 1'b1;
    while (popped < 1000 && cyc < 3000) begin
      s_valid = (pushed < 1000);
      s_data  = 32'h3000_0000 + pushed;
      @(negedge clk);
      if (s_valid && s_ready) begin
        if (first_push < 0) first_push = cyc;
        if (pushed > 0 && prev_addra == 8'd207) begin
          chk("stream_addra_wrap", mem_addra, 0);
          wrap_seen = 1'b1;
        end
        prev_addra = mem_addra;
        exp_q.push_back(s_data);
        pushed++;
      end
      if (m_valid && m_ready) begin
        if (first_out < 0) first_out = cyc;
        started = 1'b1;
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        chk("stream_data", m_data, got);
        popped++;
      end else if (started) begin
        bubbles++;
      end
      cyc++;
      next_cycle();
    end
    s_valid = 1'b0;
    chk("stream_popped", popped, 1000);
    chk("stream_latency", first_out - first_push, 3);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_wrap_seen", wrap_seen, 1);

    // ---------------- random back-pressure ----------------
    exp_q.delete();
    pushed = 0; popped = 0; cyc = 0;
    prev_stall = 1'b0; prev_data = '0;
    while (popped < 5000 && cyc < 20000) begin
      s_valid = (pushed < 5000);
      s_data  = 32'h5000_0000 + pushed;
      m_ready = ($urandom_range(0, 9) >= 3);
      @(negedge clk);
      if (prev_stall) begin
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        pushed++;
      end
      if (m_valid && m_ready) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        chk("bp_data", m_data, got);
        popped++;
      end
      cyc++;
      next_cycle();
    end
    s_valid = 1'b0;
    chk("bp_popped", popped, 5000);
    chk("bp_queue_empty", exp_q.size(), 0);

    // ---------------- clear during a read ----------------
    m_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h7000_0000 + i;
      next_cycle();
    end
    s_valid = 1'b0;
    repeat (4) next_cycle();
    m_ready = 1'b1;
    @(negedge clk);
    chk("clr_pre_issue", mem_enb, 1);
    next_cycle();
    clear = 1'b1;
    @(negedge clk);
    chk("clr_s_ready", s_ready, 0);
    chk("clr_mem_enb", mem_enb, 0);
    next_cycle();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_m_valid", m_valid, 0);
`ifdef DPRAM_FIFO_LEVEL_EN
    chk("clr_level", level, 0);
`endif
    next_cycle();
    s_valid = 1'b1;
    s_data  = 32'h1234;
    next_cycle();
    s_valid = 1'b0;
    outs = 0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) begin
        if (outs == 0) got = m_data;
        outs++;
      end
      next_cycle();
    end
    chk("clr_new_count", outs, 1);
    chk("clr_new_data", got, 32'h1234);

    // ---------------- async reset mid-stream ----------------
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 32'h9000_0000 + i;
      next_cycle();
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_mem_ena", mem_ena, 0);
    chk("arst_mem_enb", mem_enb, 0);
    chk("arst_m_data", m_data, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("arst_s_ready", s_ready, 1);
      if (m_valid) stale++;
      next_cycle();
    end
    chk("arst_no_stale", stale, 0);
    s_valid = 1'b1;
    s_data  = 32'hBEEF;
    next_cycle();
    s_valid = 1'b0;
    outs = 0;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_valid) begin
        if (outs == 0) got = m_data;
        outs++;
      end
      next_cycle();
    end
    chk("arst_new_count", outs, 1);
    chk("arst_new_data", got, 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
